dca_step_dispatcher: RTL and testbench

// - Downstream stage of the NeuGEMM sequencer. Buffers blocked step instructions in order and

---
 rtl/dca_step_dispatcher_pkg.sv | 39 +++
 rtl/dca_step_fifo.sv | 66 ++++++
 rtl/dca_step_dispatcher.sv | 158 +++++++++++++++
 tb/tb_dca_step_dispatcher.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_step_dispatcher_pkg.sv
// Package for the NeuGEMM step dispatcher.
// Provides the opcode bit positions used to decode a step instruction, the
// default instruction width and FIFO depth, a decoded-needs struct, and the
// decode helper shared by the dispatcher.
package dca_step_dispatcher_pkg;

    // Default width of a blocked step instruction; the opcode lives in the LSBs.
    localparam int BW_BLOCKED_STEP_INST = 16;

    // Default depth of the step FIFO.
    localparam int DCA_STEP_DISPATCH_FIFO_DEPTH_DEFAULT = 4;

    // Opcode bit positions inside the step instruction.
    localparam int DCA_NEUGEMM_OPCODE_INDEX_LSU0_REQ = 0;
    localparam int DCA_NEUGEMM_OPCODE_INDEX_LSU1_REQ = 1;
    localparam int DCA_NEUGEMM_OPCODE_INDEX_LSU2_REQ = 2;
    localparam int DCA_NEUGEMM_OPCODE_INDEX_LOAD_ACC = 3;

    // Number of opcode bits the decoder looks at.
    localparam int BW_OPCODE = 4;

    // What a step needs before (or causes when) it fires.
    typedef struct packed {
        logic need0;    // waits on an LSU0 read
        logic need1;    // waits on an LSU1 read
        logic need2r;   // waits on an LSU2 accumulator load
        logic is_wr;    // launches an LSU2 store once it fires
    } step_needs_t;

    function automatic step_needs_t decode_opcode(input logic [BW_OPCODE-1:0] opc);
        step_needs_t n;
        n.need0  = opc[DCA_NEUGEMM_OPCODE_INDEX_LSU0_REQ];
        n.need1  = opc[DCA_NEUGEMM_OPCODE_INDEX_LSU1_REQ];
        n.need2r = opc[DCA_NEUGEMM_OPCODE_INDEX_LSU2_REQ] &  opc[DCA_NEUGEMM_OPCODE_INDEX_LOAD_ACC];
        n.is_wr  = opc[DCA_NEUGEMM_OPCODE_INDEX_LSU2_REQ] & ~opc[DCA_NEUGEMM_OPCODE_INDEX_LOAD_ACC];
        return n;
    endfunction

endpackage

// File: rtl/dca_step_fifo.sv
// Synchronous FIFO holding step instructions for the dispatcher.
// Storage only: no decode, no credits.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high flush (reset or clear)
//   push   in   write din (ignored while full)
//   din    in   WIDTH-bit data to write
//   pop    in   drop the head entry (ignored while empty)
//   head   out  current head entry, from registered state (no bypass)
//   full   out  all DEPTH entries occupied
//   empty  out  no entries
module dca_step_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = ((wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is read straight from the array: a push at edge T is visible at T+1.
    assign head = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/dca_step_dispatcher.sv
// NeuGEMM step dispatcher.
// Queues step instructions in order and presents the head to the compute
// core once the LSU loads it depends on have completed. LSU completions are
// banked as credits (they may arrive before their step). Outstanding LSU2
// stores are counted so idle only asserts once all traffic has drained.
// Ports:
//   clk, rst, clear        clock, synchronous reset, synchronous flush
//   step_valid/ready/inst  step input from the sequencer
//   lsu0_done, lsu1_done   one LSU0 / LSU1 read completed (pulse)
//   lsu2_rdone             one LSU2 accumulator load completed (pulse)
//   lsu2_wdone             one LSU2 store completed (pulse)
//   core_valid/ready/inst  step output to the compute core
//   idle                   FIFO empty and every counter zero
//   error                  sticky counter overflow/underflow
module dca_step_dispatcher
    import dca_step_dispatcher_pkg::*;
#(
    parameter int BW_STEP_INST = BW_BLOCKED_STEP_INST,
    parameter int FIFO_DEPTH   = DCA_STEP_DISPATCH_FIFO_DEPTH_DEFAULT,
    parameter int BW_CNT       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    step_valid,
    output logic                    step_ready,
    input  logic [BW_STEP_INST-1:0] step_inst,
    input  logic                    lsu0_done,
    input  logic                    lsu1_done,
    input  logic                    lsu2_rdone,
    input  logic                    lsu2_wdone,
    output logic                    core_valid,
    input  logic                    core_ready,
    output logic [BW_STEP_INST-1:0] core_inst,
    output logic                    idle,
    output logic                    error
);

    localparam int NCR = 3;     // credit counters: LSU0, LSU1, LSU2 acc load
    localparam logic [BW_CNT-1:0] CNT_ONE = {{(BW_CNT-1){1'b0}}, 1'b1};
    localparam logic [BW_CNT-1:0] CNT_MAX = '1;

    logic                    flush;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [BW_STEP_INST-1:0] head;
    logic                    fire;
    step_needs_t             needs;

    logic [NCR-1:0]          cr_need;
    logic [NCR-1:0]          cr_inc;
    logic [NCR-1:0]          cr_dec;
    logic [NCR-1:0]          cr_ok;
    logic [NCR-1:0]          cr_zero;
    logic [NCR-1:0]          cr_ovf;
    logic [BW_CNT-1:0]       cr_reg  [NCR];
    logic [BW_CNT-1:0]       cr_next [NCR];

    logic [BW_CNT-1:0]       wr_pend_reg;
    logic [BW_CNT-1:0]       wr_pend_next;
    logic                    wr_inc;
    logic                    wr_err;
    logic                    error_reg;
    logic                    error_next;

    assign flush = rst | clear;

    dca_step_fifo #(
        .WIDTH (BW_STEP_INST),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (flush),
        .push  (step_valid & step_ready),
        .din   (step_inst),
        .pop   (fire),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign needs   = decode_opcode(head[BW_OPCODE-1:0]);
    assign cr_need = {needs.need2r, needs.need1, needs.need0};
    assign cr_inc  = {lsu2_rdone, lsu1_done, lsu0_done};

    generate
        for (genvar gi = 0; gi < NCR; gi++) begin : g_cr
            assign cr_zero[gi] = (cr_reg[gi] == '0);
            assign cr_ok[gi]   = ~cr_need[gi] | ~cr_zero[gi];
            // Only consumed on fire, and fire requires a non-zero credit,
            // so a decrement can never underflow.
            assign cr_dec[gi]  = fire & cr_need[gi];
        end
    endgenerate

    // Depends only on registered state, never on core_ready.
    assign core_valid = ~fifo_empty & (&cr_ok);
    assign fire       = core_valid & core_ready;
    assign core_inst  = head;
    assign step_ready = ~fifo_full;
    assign wr_inc     = fire & needs.is_wr;

    always_comb begin
        for (int i = 0; i < NCR; i++) begin
            cr_next[i] = cr_reg[i];
            cr_ovf[i]  = 1'b0;
            if (cr_inc[i] & ~cr_dec[i]) begin
                if (cr_reg[i] == CNT_MAX) begin
                    cr_ovf[i] = 1'b1;   // saturate
                end else begin
                    cr_next[i] = cr_reg[i] + CNT_ONE;
                end
            end else if (~cr_inc[i] & cr_dec[i]) begin
                cr_next[i] = cr_reg[i] - CNT_ONE;
            end
        end
    end

    always_comb begin
        wr_pend_next = wr_pend_reg;
        wr_err       = 1'b0;
        if (wr_inc & ~lsu2_wdone) begin
            if (wr_pend_reg == CNT_MAX) begin
                wr_err = 1'b1;
            end else begin
                wr_pend_next = wr_pend_reg + CNT_ONE;
            end
        end else if (~wr_inc & lsu2_wdone) begin
            if (wr_pend_reg == '0) begin
                wr_err = 1'b1;          // store completion with nothing outstanding
            end else begin
                wr_pend_next = wr_pend_reg - CNT_ONE;
            end
        end
    end

    assign error_next = error_reg | (|cr_ovf) | wr_err;

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < NCR; i++) begin
                cr_reg[i] <= '0;
            end
            wr_pend_reg <= '0;
            error_reg   <= 1'b0;
        end else begin
            for (int i = 0; i < NCR; i++) begin
                cr_reg[i] <= cr_next[i];
            end
            wr_pend_reg <= wr_pend_next;
            error_reg   <= error_next;
        end
    end

    assign idle  = fifo_empty & (&cr_zero) & (wr_pend_reg == '0);
    assign error = error_reg;

endmodule

// File: tb/tb_dca_step_dispatcher.sv
// Testbench for dca_step_dispatcher: table of per-cycle vectors plus a
// hand-written credit-overflow sequence. Each row gives the outputs expected
// in a cycle (before that cycle's edge) and the inputs driven into that edge.
// Opcode bits: 1=LSU0_REQ 2=LSU1_REQ 4=LSU2_REQ 8=LOAD_ACC.
module tb_dca_step_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        step_valid;
    logic        step_ready;
    logic [15:0] step_inst;
    logic        lsu0_done;
    logic        lsu1_done;
    logic        lsu2_rdone;
    logic        lsu2_wdone;
    logic        core_valid;
    logic        core_ready;
    logic [15:0] core_inst;
    logic        idle;
    logic        error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dca_step_dispatcher dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_inst  (step_inst),
        .lsu0_done  (lsu0_done),
        .lsu1_done  (lsu1_done),
        .lsu2_rdone (lsu2_rdone),
        .lsu2_wdone (lsu2_wdone),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .core_inst  (core_inst),
        .idle       (idle),
        .error      (error)
    );

    typedef struct {
        logic        clr;
        logic        sv;
        logic [15:0] si;
        logic        d0, d1, d2r, d2w;
        logic        cr;
        logic        e_srdy;
        logic        e_cv;
        logic [15:0] e_ci;
        logic        e_idle;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic clr, input logic sv, input logic [15:0] si,
        input logic d0, input logic d1, input logic d2r, input logic d2w,
        input logic cr,
        input logic e_srdy, input logic e_cv, input logic [15:0] e_ci,
        input logic e_idle, input logic e_err);
        vec_t v;
        v.clr = clr; v.sv = sv; v.si = si;
        v.d0 = d0; v.d1 = d1; v.d2r = d2r; v.d2w = d2w; v.cr = cr;
        v.e_srdy = e_srdy; v.e_cv = e_cv; v.e_ci = e_ci;
        v.e_idle = e_idle; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        clear = 0; step_valid = 0; step_inst = '0;
        lsu0_done = 0; lsu1_done = 0; lsu2_rdone = 0; lsu2_wdone = 0;
        core_ready = 0;
    endtask

    initial begin
        logic seen;

        rst = 1'b1;
        quiet_inputs();

        // ---------------- reset ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_step_ready", step_ready, 1);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_error", error, 0);
        @(negedge clk);
        rst = 1'b0;
        $display("reset: step_ready=%0b core_valid=%0b idle=%0b error=%0b",
                 step_ready, core_valid, idle, error);

        // ---------------- vector table ----------------
        // dependency stall: needs LSU0 and LSU1
        vecs.push_back(mk(0,1,16'h1003,0,0,0,0,1, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0,0,1, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,0,0,1, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h1003,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,1,0));
        // early credits then 3 back-to-back LSU0 steps
        vecs.push_back(mk(0,0,16'h0000,1,0,0,0,0, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0,0,0, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0,0,0, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,1,16'h2001,0,0,0,0,1, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,1,16'h2101,0,0,0,0,1, 1,1,16'h2001,0,0));
        vecs.push_back(mk(0,1,16'h2201,0,0,0,0,1, 1,1,16'h2101,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h2201,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,1,0));
        // full / backpressure
        vecs.push_back(mk(0,1,16'h3000,0,0,0,0,0, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,1,16'h3100,0,0,0,0,0, 1,1,16'h3000,0,0));
        vecs.push_back(mk(0,1,16'h3200,0,0,0,0,0, 1,1,16'h3000,0,0));
        vecs.push_back(mk(0,1,16'h3300,0,0,0,0,0, 1,1,16'h3000,0,0));
        vecs.push_back(mk(0,1,16'h3400,0,0,0,0,0, 0,1,16'h3000,0,0));
        vecs.push_back(mk(0,1,16'h3400,0,0,0,0,1, 0,1,16'h3000,0,0));
        vecs.push_back(mk(0,1,16'h3400,0,0,0,0,1, 1,1,16'h3100,0,0));
        vecs.push_back(mk(0,1,16'h3500,0,0,0,0,1, 1,1,16'h3200,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h3300,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h3400,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h3500,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,1,0));
        // store drain and sticky error
        vecs.push_back(mk(0,1,16'h4004,0,0,0,0,1, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h4004,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,1,0, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,1,0, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,1,16'h4100,0,0,0,0,1, 1,0,16'h0000,1,1));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h4100,0,1));
        vecs.push_back(mk(1,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,1,1));
        // LSU2 accumulator load, with a credit arriving on the fire cycle
        vecs.push_back(mk(0,1,16'h500C,0,0,0,0,1, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,0,1, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1,0,1, 1,1,16'h500C,0,0));
        vecs.push_back(mk(0,1,16'h510C,0,0,0,0,1, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,1,16'h510C,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,1,0));
        // flush mid-operation: 2 queued steps, cr1=2
        vecs.push_back(mk(0,1,16'h6002,0,1,0,0,0, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,1,16'h6102,0,1,0,0,0, 1,1,16'h6002,0,0));
        vecs.push_back(mk(1,0,16'h0000,0,0,0,0,0, 1,1,16'h6002,0,0));
        vecs.push_back(mk(0,1,16'h7002,0,0,0,0,1, 1,0,16'h0000,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,1, 1,0,16'h0000,0,0));
        vecs.push_back(mk(1,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,0,0,0, 1,0,16'h0000,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clear      = vecs[i].clr;
            step_valid = vecs[i].sv;
            step_inst  = vecs[i].si;
            lsu0_done  = vecs[i].d0;
            lsu1_done  = vecs[i].d1;
            lsu2_rdone = vecs[i].d2r;
            lsu2_wdone = vecs[i].d2w;
            core_ready = vecs[i].cr;
            #1;
            chk($sformatf("v%0d_step_ready", i), step_ready, vecs[i].e_srdy);
            chk($sformatf("v%0d_core_valid", i), core_valid, vecs[i].e_cv);
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d_core_inst", i), core_inst, vecs[i].e_ci);
            end
            chk($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
            chk($sformatf("v%0d_error", i), error, vecs[i].e_err);
            $display("vec %0d: sv=%0b si=%04h cr=%0b -> step_ready=%0b core_valid=%0b core_inst=%04h idle=%0b error=%0b",
                     i, vecs[i].sv, vecs[i].si, vecs[i].cr, step_ready, core_valid,
                     core_inst, idle, error);
        end

        // ---------------- credit overflow ----------------
        // 7 pulses fill a 3-bit counter; the 8th overflows, sets error and saturates.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            quiet_inputs();
            lsu0_done = 1'b1;
        end
        @(negedge clk);
        quiet_inputs();
        #1;
        chk("ovf_error_before", error, 0);
        chk("ovf_idle_before", idle, 0);
        lsu0_done = 1'b1;
        @(negedge clk);
        quiet_inputs();
        #1;
        chk("ovf_error_set", error, 1);
        $display("overflow: error=%0b idle=%0b", error, idle);

        // dispatch continues with error set; bounded wait for the step to appear
        step_valid = 1'b1;
        step_inst  = 16'h8001;
        core_ready = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 8; w++) begin
            #1;
            if (core_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ovf_wait_core_valid", seen, 1);
        if (seen) begin
            chk("ovf_core_inst", core_inst, 16'h8001);
        end
        @(negedge clk);
        core_ready = 1'b0;
        #1;
        chk("ovf_core_valid_after", core_valid, 0);
        chk("ovf_idle_after", idle, 0);
        chk("ovf_error_sticky", error, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("ovf_clear_idle", idle, 1);
        chk("ovf_clear_error", error, 0);
        $display("overflow clear: idle=%0b error=%0b", idle, error);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
